alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR, default 1, 1 = round-robin grant, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_rs, req0_rt  input  32 each  requester 0 operands.
REQ-007 req0_shamt  input  5  requester 0 shift amount.
REQ-008 req0_funct  input  6  requester 0 function code.
REQ-009 req1_valid, req1_ready, req1_rs, req1_rt, req1_shamt, req1_funct: same as REQ-004..008 for requester 1.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_rd  output  32  result.
REQ-013 out_id  output  1  requester index owning the result.
REQ-014 out_err  output  1  funct was not add/sub/srl.

Function
REQ-015 FSM states IDLE, EXEC, DONE; IDLE on reset.
REQ-016 IDLE: if any reqN_valid, grant one; reqN_ready high for that requester only, in that cycle only; latch rs, rt, shamt, funct, id; go EXEC.
REQ-017 reqN_ready SHALL be 0 in EXEC and DONE and for the non-granted requester.
REQ-018 Single valid: that requester granted regardless of RR.
REQ-019 Both valid, RR=1: grant requester indicated by priority pointer; pointer toggles to the other requester after every grant.
REQ-020 Both valid, RR=0: requester 0 always granted.
REQ-021 EXEC: shared ALU evaluates latched operands; register rd, id, err; go DONE.
REQ-022 ALU functions: 100000 rd=rs+rt, 100010 rd=rs-rt, 000010 rd=rt>>shamt logical; 32-bit, wrap-around modulo 2^32, no overflow flag.
REQ-023 Any other funct: out_rd=0, out_err=1, still completes normally.
REQ-024 DONE: out_valid=1 with out_rd/out_id/out_err stable until out_ready sampled high; then go IDLE.
REQ-025 Latency: grant at cycle N -> out_valid at N+2 earliest; max one op per 3 cycles.
REQ-026 out_valid, out_rd, out_id, out_err change only on state transitions; no combinational path from reqN_* to out_*.
REQ-027 Requester dropping valid after grant has no effect on the op in flight.

Reset
REQ-028 rst_n low at any time (including EXEC/DONE) SHALL immediately force IDLE, discard the op in flight, and drive out_valid=0, out_rd=0, out_id=0, out_err=0, req0_ready=0, req1_ready=0, priority pointer=0 (requester 0 first).
REQ-029 First grant possible on the first rising clk after rst_n deasserts.

Structure
REQ-030 Shared package alu_pkg holds funct constants (ADD=100000, SUB=100010, SRL=000010), FSM state enum, data width 32.
REQ-031 Datapath is one instance of existing sub-module alu (rs, rt, shamt, funct -> rd); the arbiter holds only sequencing, latches and decode of out_err.

Verification
REQ-032 req0 only: rs=0, rt=1, funct=100000 -> out_rd=1, out_id=0, out_err=0, out_valid 2 cycles after grant.
REQ-033 Both valid same cycle, RR=1, after reset: req0 (rs=7, rt=3, funct=100010) then req1 (rt=8, shamt=2, funct=000010) -> results 4 (id 0) then 2 (id 1); with both held, grants alternate 0,1,0,1.
REQ-034 Wrap: rs=0, rt=1, funct=100010 -> out_rd=FFFFFFFF; rs=FFFFFFFF, rt=1, add -> out_rd=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_rd held, both reqN_ready stay 0; out_ready=1 -> IDLE next cycle.
REQ-036 funct=100100 -> out_err=1, out_rd=0; rst_n pulsed low during EXEC -> out_valid never asserts for that op, all outputs 0, next grant to req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: data widths, function codes,
// FSM state encoding and the legal-function decode.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the function codes the ALU implements.
    function automatic logic funct_is_legal(input logic [FUNCT_W-1:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_SRL);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, subtract, logical shift right of rt.
// Results wrap modulo 2^DATA_W; unknown function codes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  rs_i,
    input  logic [DATA_W-1:0]  rt_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [DATA_W-1:0]  rd_o
);

    // Select the operation result from the function code.
    always_comb begin
        // NOTE: default assignment first so no path leaves rd_o unassigned (no latch).
        rd_o = '0;
        case (funct_i)
            FUNCT_ADD: rd_o = rs_i + rt_i;
            FUNCT_SUB: rd_o = rs_i - rt_i;
            FUNCT_SRL: rd_o = rt_i >> shamt_i;
            default:   rd_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU. Grants one requester in IDLE,
// evaluates the latched operands in EXEC and holds the result in DONE until
// the consumer takes it. RR selects round-robin or fixed priority to req0.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_rs,
    input  logic [DATA_W-1:0]  req0_rt,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [FUNCT_W-1:0] req0_funct,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_rs,
    input  logic [DATA_W-1:0]  req1_rt,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [FUNCT_W-1:0] req1_funct,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_rd,
    output logic               out_id,
    output logic               out_err
);

    state_t               state_q;
    logic                 prio_q;      // 1: req1 wins a tie (round-robin only)
    logic [DATA_W-1:0]    op_rs_q;
    logic [DATA_W-1:0]    op_rt_q;
    logic [SHAMT_W-1:0]   op_shamt_q;
    logic [FUNCT_W-1:0]   op_funct_q;
    logic                 op_id_q;
    logic                 out_valid_q;
    logic [DATA_W-1:0]    out_rd_q;
    logic                 out_id_q;
    logic                 out_err_q;

    logic                 gnt_any;
    logic                 gnt_id;
    logic [DATA_W-1:0]    alu_rd;

    // Grant decision: a lone requester always wins; a tie goes to req1 only
    // when round-robin is enabled and the pointer favours it.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = req1_valid & (~req0_valid | (RR & prio_q));
    end

    // Handshake is only offered in IDLE; rst_n gating keeps it low while the
    // asynchronous reset holds the FSM in IDLE.
    assign req0_ready = rst_n & (state_q == ST_IDLE) & gnt_any & ~gnt_id;
    assign req1_ready = rst_n & (state_q == ST_IDLE) & gnt_any &  gnt_id;

    alu u_alu (
        .rs_i    (op_rs_q),
        .rt_i    (op_rt_q),
        .shamt_i (op_shamt_q),
        .funct_i (op_funct_q),
        .rd_o    (alu_rd)
    );

    // Sequencer: latch the granted op, register the ALU result, hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            op_rs_q     <= '0;
            op_rt_q     <= '0;
            op_shamt_q  <= '0;
            op_funct_q  <= '0;
            op_id_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_id_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        op_rs_q    <= gnt_id ? req1_rs    : req0_rs;
                        op_rt_q    <= gnt_id ? req1_rt    : req0_rt;
                        op_shamt_q <= gnt_id ? req1_shamt : req0_shamt;
                        op_funct_q <= gnt_id ? req1_funct : req0_funct;
                        op_id_q    <= gnt_id;
                        prio_q     <= ~gnt_id;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_rd_q    <= alu_rd;
                    out_id_q    <= op_id_q;
                    out_err_q   <= ~funct_is_legal(op_funct_q);
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_id    = out_id_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance under full checking
// plus a fixed-priority instance on the same inputs for grant ordering.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req0_valid, req1_valid;
    logic [31:0]        req0_rs, req0_rt, req1_rs, req1_rt;
    logic [4:0]         req0_shamt, req1_shamt;
    logic [5:0]         req0_funct, req1_funct;
    logic               out_ready;

    logic               req0_ready, req1_ready, out_valid, out_id, out_err;
    logic [31:0]        out_rd;
    logic               fp_req0_ready, fp_req1_ready, fp_out_valid, fp_out_id, fp_out_err;
    logic [31:0]        fp_out_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs(req0_rs),
        .req0_rt(req0_rt), .req0_shamt(req0_shamt), .req0_funct(req0_funct),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs(req1_rs),
        .req1_rt(req1_rt), .req1_shamt(req1_shamt), .req1_funct(req1_funct),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_id(out_id), .out_err(out_err)
    );

    alu_arbiter #(.RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_rs(req0_rs),
        .req0_rt(req0_rt), .req0_shamt(req0_shamt), .req0_funct(req0_funct),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_rs(req1_rs),
        .req1_rt(req1_rt), .req1_shamt(req1_shamt), .req1_funct(req1_funct),
        .out_valid(fp_out_valid), .out_ready(out_ready), .out_rd(fp_out_rd),
        .out_id(fp_out_id), .out_err(fp_out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req0(input logic v, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [4:0] sh, input logic [5:0] f);
        req0_valid = v; req0_rs = rs; req0_rt = rt; req0_shamt = sh; req0_funct = f;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [4:0] sh, input logic [5:0] f);
        req1_valid = v; req1_rs = rs; req1_rt = rt; req1_shamt = sh; req1_funct = f;
    endtask

    // Called just after a rising edge with the DUT in IDLE and requests driven.
    // Checks grant, EXEC and DONE cycles; returns just after the edge back to IDLE.
    task automatic expect_op(input string tag, input logic exp_id, input logic [31:0] exp_rd,
                             input logic exp_err, input bit drop);
        logic fp_id;
        @(negedge clk);
        check({tag, ".gnt.rdy0"}, 32'(req0_ready), 32'(!exp_id));
        check({tag, ".gnt.rdy1"}, 32'(req1_ready), 32'(exp_id));
        fp_id = !req0_valid;
        check({tag, ".gnt.fp_rdy0"}, 32'(fp_req0_ready), 32'(!fp_id));
        check({tag, ".gnt.fp_rdy1"}, 32'(fp_req1_ready), 32'(fp_id));
        check({tag, ".gnt.valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        @(negedge clk);
        check({tag, ".exec.rdy0"}, 32'(req0_ready), 32'd0);
        check({tag, ".exec.rdy1"}, 32'(req1_ready), 32'd0);
        check({tag, ".exec.valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, ".done.valid"}, 32'(out_valid), 32'd1);
        check({tag, ".done.rd"}, out_rd, exp_rd);
        check({tag, ".done.id"}, 32'(out_id), 32'(exp_id));
        check({tag, ".done.err"}, 32'(out_err), 32'(exp_err));
        check({tag, ".done.rdy0"}, 32'(req0_ready), 32'd0);
        check({tag, ".done.rdy1"}, 32'(req1_ready), 32'd0);
        check({tag, ".done.fp_id"}, 32'(fp_out_id), 32'(fp_id));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_req0(1'b0, 32'd0, 32'd0, 5'd0, 6'd0);
        set_req1(1'b0, 32'd0, 32'd0, 5'd0, 6'd0);

        // Reset state, with requests pending to show ready stays low.
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.rd",    out_rd,         32'd0);
        check("rst.id",    32'(out_id),    32'd0);
        check("rst.err",   32'(out_err),   32'd0);
        check("rst.rdy0",  32'(req0_ready), 32'd0);
        check("rst.rdy1",  32'(req1_ready), 32'd0);

        // req0 alone, granted on the first edge after reset release: 0 + 1.
        @(posedge clk); #1;
        rst_n = 1'b1;
        req1_valid = 1'b0;
        set_req0(1'b1, 32'd0, 32'd1, 5'd0, FUNCT_ADD);
        expect_op("t1_add", 1'b0, 32'd1, 1'b0, 1'b1);

        // Both held after reset: 7-3=4 from req0, 8>>2=2 from req1, alternating.
        do_reset();
        set_req0(1'b1, 32'd7, 32'd3, 5'd0, FUNCT_SUB);
        set_req1(1'b1, 32'd5, 32'd8, 5'd2, FUNCT_SRL);
        expect_op("t2_rr0", 1'b0, 32'd4, 1'b0, 1'b0);
        expect_op("t2_rr1", 1'b1, 32'd2, 1'b0, 1'b0);
        expect_op("t2_rr2", 1'b0, 32'd4, 1'b0, 1'b0);
        expect_op("t2_rr3", 1'b1, 32'd2, 1'b0, 1'b1);

        // Wrap-around: 0-1 from req1, then FFFFFFFF+1 from req0.
        set_req1(1'b1, 32'd0, 32'd1, 5'd0, FUNCT_SUB);
        expect_op("t3_sub_wrap", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        set_req0(1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, FUNCT_ADD);
        expect_op("t3_add_wrap", 1'b0, 32'd0, 1'b0, 1'b1);

        // Backpressure: 10+20 held in DONE for 5 cycles while req1 waits.
        out_ready = 1'b0;
        set_req0(1'b1, 32'd10, 32'd20, 5'd0, FUNCT_ADD);
        @(negedge clk);
        check("t4.gnt.rdy0", 32'(req0_ready), 32'd1);
        check("t4.gnt.rdy1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req1(1'b1, 32'd2, 32'd3, 5'd0, FUNCT_ADD);
        @(negedge clk);
        check("t4.exec.valid", 32'(out_valid), 32'd0);
        check("t4.exec.rdy1",  32'(req1_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4.hold.valid", 32'(out_valid), 32'd1);
            check("t4.hold.rd",    out_rd,          32'd30);
            check("t4.hold.id",    32'(out_id),     32'd0);
            check("t4.hold.rdy0",  32'(req0_ready), 32'd0);
            check("t4.hold.rdy1",  32'(req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4.release.valid", 32'(out_valid), 32'd1);
        check("t4.release.rd",    out_rd,         32'd30);
        @(posedge clk); #1;
        expect_op("t4_next", 1'b1, 32'd5, 1'b0, 1'b1);

        // Illegal function code: zero result, error flag.
        set_req0(1'b1, 32'd5, 32'd6, 5'd0, 6'b100100);
        expect_op("t5_err", 1'b0, 32'd0, 1'b1, 1'b1);

        // Reset during EXEC: pointer favours req1 here, op must vanish.
        set_req0(1'b1, 32'd7, 32'd3, 5'd0, FUNCT_SUB);
        set_req1(1'b1, 32'd9, 32'd9, 5'd0, FUNCT_ADD);
        @(negedge clk);
        check("t6.gnt.rdy0", 32'(req0_ready), 32'd0);
        check("t6.gnt.rdy1", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst.valid", 32'(out_valid),  32'd0);
        check("t6.rst.rd",    out_rd,          32'd0);
        check("t6.rst.id",    32'(out_id),     32'd0);
        check("t6.rst.err",   32'(out_err),    32'd0);
        check("t6.rst.rdy0",  32'(req0_ready), 32'd0);
        check("t6.rst.rdy1",  32'(req1_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6.rst.hold_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        expect_op("t6_after_rst", 1'b0, 32'd4, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
